wait_state_server: RTL and testbench

// Server-side responder for the client/arbiter rq/ack bus; sits where the RAM server sits, behind the bus arbiter.

---
 rtl/wait_state_server.sv | 152 +++++++++++++++
 tb/tb_wait_state_server.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_server.sv
// Register-file bus responder that inserts fixed or LFSR-random wait states
// before ack, flags initiator protocol violations and counts completed transactions.
module wait_state_server #(
  parameter int         DATA_WIDTH   = 8,
  parameter int         ADDR_WIDTH   = 4,
  parameter int         MEMORY_DEPTH = 16,
  parameter int         WAIT_MODE    = 0,
  parameter int         FIXED_WAIT   = 2,
  parameter int         MAX_WAIT     = 7,
  parameter logic [4:0] LFSR_SEED    = 5'b10101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  input  logic                  err_clr,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dataR,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [15:0]           txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  localparam logic [4:0]          SEED_EFF   = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
  localparam logic [4:0]          WAIT_MASK  = 5'(MAX_WAIT);
  localparam logic [4:0]          WAIT_FIXED = 5'(FIXED_WAIT);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM  = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [4:0]              lfsr_q, lfsr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   dataR_q, dataR_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [15:0]             txn_q, txn_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [MEMORY_DEPTH];

  logic [4:0]              wait_load;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    addr_ok;
  logic [DATA_WIDTH-1:0]   rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    data_d  = data_q;
    dataR_d = dataR_q;
    err_d   = err_q;
    txn_d   = txn_q;
    mem_d   = mem_q;
    lfsr_d  = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

    wait_load = (WAIT_MODE != 0) ? (lfsr_q & WAIT_MASK) : WAIT_FIXED;
    // In IDLE the request is accepted straight from the bus, later from the latched copy
    acc_addr  = (state_q == S_IDLE) ? address : addr_q;
    addr_ok   = ({1'b0, acc_addr} < DEPTH_LIM);
    rd_data   = '0;
    if (addr_ok) rd_data = mem_q[acc_addr];

    if (err_clr) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rq) begin
          addr_d = address;
          wr_d   = wr_ni;
          data_d = dataW;
          cnt_d  = wait_load;
          if (wait_load != 5'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ACK;
            if (!wr_ni) dataR_d = rd_data;
          end
        end
      end
      S_WAIT: begin
        if (!rq) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if ((address != addr_q) || (wr_ni != wr_q) || (dataW != data_q)) err_d = 1'b1;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = S_ACK;
            if (!wr_q) dataR_d = rd_data;
          end
        end
      end
      S_ACK: begin
        if (wr_q && addr_ok) mem_d[addr_q] = data_q;
        txn_d   = txn_q + 16'd1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!rq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED_EFF;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      dataR_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      txn_q   <= '0;
      for (int i = 0; i < MEMORY_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      dataR_q <= dataR_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
      mem_q   <= mem_d;
    end
  end

  assign ack          = ack_q;
  assign dataR        = dataR_q;
  assign busy         = busy_q;
  assign protocol_err = err_q;
  assign txn_count    = txn_q;

endmodule

// File: tb/tb_wait_state_server.sv
// Scoreboard bench for wait_state_server: three instances (fixed wait 2,
// fixed wait 0, random wait with 12-word memory) exercised one at a time.
module tb_wait_state_server;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetA [3];
   logic        rqA    [3];
   logic        wrA    [3];
   logic [3:0]  addrA  [3];
   logic [7:0]  dwA    [3];
   logic        clrA   [3];
   logic        ackA   [3];
   logic [7:0]  drA    [3];
   logic        busyA  [3];
   logic        errA   [3];
   logic [15:0] txnA   [3];

   wait_state_server #(.FIXED_WAIT(2)) dut0 (
      .clk(clk), .reset(resetA[0]), .address(addrA[0]), .rq(rqA[0]), .wr_ni(wrA[0]),
      .dataW(dwA[0]), .err_clr(clrA[0]), .ack(ackA[0]), .dataR(drA[0]), .busy(busyA[0]),
      .protocol_err(errA[0]), .txn_count(txnA[0]));

   wait_state_server #(.FIXED_WAIT(0)) dut1 (
      .clk(clk), .reset(resetA[1]), .address(addrA[1]), .rq(rqA[1]), .wr_ni(wrA[1]),
      .dataW(dwA[1]), .err_clr(clrA[1]), .ack(ackA[1]), .dataR(drA[1]), .busy(busyA[1]),
      .protocol_err(errA[1]), .txn_count(txnA[1]));

   wait_state_server #(.WAIT_MODE(1), .LFSR_SEED(5'b00111), .MEMORY_DEPTH(12)) dut2 (
      .clk(clk), .reset(resetA[2]), .address(addrA[2]), .rq(rqA[2]), .wr_ni(wrA[2]),
      .dataW(dwA[2]), .err_clr(clrA[2]), .ack(ackA[2]), .dataR(drA[2]), .busy(busyA[2]),
      .protocol_err(errA[2]), .txn_count(txnA[2]));

   typedef struct {
      logic        chkData;
      logic [7:0]  data;
      logic [15:0] txn;
      int          minCyc;
      int          maxCyc;
   } exp_t;

   exp_t       expQ[$];
   int         sel = 0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         expTxn [3];
   logic [7:0] latMask = '0;

   // Cycle counter used to time ack arrival against the issue cycle
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every ack of the selected instance is matched against the next expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      int   lat;
      if (ackA[sel] === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_ack: inst=%0d cyc=%0d got ack=1 expected no ack", sel, cyc);
         end else begin
            e = expQ.pop_front();
            total++;
            if (cyc < e.minCyc || cyc > e.maxCyc) begin
               bad++;
               $display("[TB] FAIL ack_cycle: inst=%0d got cyc=%0d expected %0d..%0d", sel, cyc, e.minCyc, e.maxCyc);
            end
            if (e.chkData) checkOutput("ack_dataR", {24'd0, drA[sel]}, {24'd0, e.data});
            checkOutput("ack_txn", {16'd0, txnA[sel]}, {16'd0, e.txn});
            lat = cyc - e.minCyc;
            if (sel == 2 && lat >= 0 && lat < 8) latMask[lat] = 1'b1;
         end
      end
   end

   task automatic applyStimulus(input int s, input logic wr, input logic [3:0] a, input logic [7:0] d,
                                input int nMin, input int nMax, input logic [7:0] expD);
      exp_t e;
      rqA[s]   = 1'b1;
      wrA[s]   = wr;
      addrA[s] = a;
      dwA[s]   = d;
      e.chkData = !wr;
      e.data    = expD;
      e.txn     = 16'(expTxn[s]);
      e.minCyc  = cyc + 1 + nMin;
      e.maxCyc  = cyc + 1 + nMax;
      expQ.push_back(e);
      expTxn[s]++;
   endtask

   task automatic waitAck(input int s);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ackA[s] === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("[TB] FAIL ack_timeout: inst=%0d got no ack expected ack within 40 cycles", s);
      end
   endtask

   // Full handshake: issue, wait for ack, drop rq, let RELEASE return to IDLE
   task automatic doTxn(input int s, input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input int nMin, input int nMax, input logic [7:0] expD);
      applyStimulus(s, wr, a, d, nMin, nMax, expD);
      waitAck(s);
      rqA[s] = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nDistinct;
      for (int i = 0; i < 3; i++) begin
         resetA[i] = 1'b0; rqA[i] = 1'b0; wrA[i] = 1'b0;
         addrA[i] = '0; dwA[i] = '0; clrA[i] = 1'b0; expTxn[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) resetA[i] = 1'b1;
      @(negedge clk);

      checkOutput("rst_ack",  {31'd0, ackA[0]}, 32'd0);
      checkOutput("rst_dataR", {24'd0, drA[0]}, 32'd0);
      checkOutput("rst_busy", {31'd0, busyA[0]}, 32'd0);
      checkOutput("rst_err",  {31'd0, errA[0]}, 32'd0);
      checkOutput("rst_txn",  {16'd0, txnA[0]}, 32'd0);

      // T1: write then read back with two wait states
      sel = 0;
      doTxn(0, 1'b1, 4'd3, 8'hA5, 2, 2, 8'h00);
      doTxn(0, 1'b0, 4'd3, 8'h00, 2, 2, 8'hA5);
      checkOutput("t1_txn", {16'd0, txnA[0]}, 32'd2);

      // T3: rq dropped during WAIT aborts the write
      rqA[0] = 1'b1; wrA[0] = 1'b1; addrA[0] = 4'd5; dwA[0] = 8'h3C;
      @(negedge clk);
      checkOutput("t3_busy_wait", {31'd0, busyA[0]}, 32'd1);
      rqA[0] = 1'b0;
      @(negedge clk);
      checkOutput("t3_err_set", {31'd0, errA[0]}, 32'd1);
      checkOutput("t3_busy_idle", {31'd0, busyA[0]}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("t3_err_sticky", {31'd0, errA[0]}, 32'd1);
      clrA[0] = 1'b1;
      @(negedge clk);
      clrA[0] = 1'b0;
      checkOutput("t3_err_clr", {31'd0, errA[0]}, 32'd0);
      doTxn(0, 1'b0, 4'd5, 8'h00, 2, 2, 8'h00);

      // T4: address changes mid-WAIT; latched address is still used
      applyStimulus(0, 1'b1, 4'd2, 8'h77, 2, 2, 8'h00);
      @(negedge clk);
      addrA[0] = 4'd6;
      waitAck(0);
      rqA[0] = 1'b0;
      addrA[0] = 4'd2;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t4_err", {31'd0, errA[0]}, 32'd1);
      doTxn(0, 1'b0, 4'd2, 8'h00, 2, 2, 8'h77);
      doTxn(0, 1'b0, 4'd6, 8'h00, 2, 2, 8'h00);
      checkOutput("t4_txn", {16'd0, txnA[0]}, 32'd6);

      // T5: reset during WAIT of a write
      rqA[0] = 1'b1; wrA[0] = 1'b1; addrA[0] = 4'd1; dwA[0] = 8'h11;
      @(negedge clk);
      resetA[0] = 1'b0;
      @(negedge clk);
      checkOutput("t5_ack", {31'd0, ackA[0]}, 32'd0);
      checkOutput("t5_busy", {31'd0, busyA[0]}, 32'd0);
      checkOutput("t5_err", {31'd0, errA[0]}, 32'd0);
      checkOutput("t5_txn", {16'd0, txnA[0]}, 32'd0);
      resetA[0] = 1'b1;
      rqA[0] = 1'b0;
      expTxn[0] = 0;
      @(negedge clk);
      doTxn(0, 1'b0, 4'd1, 8'h00, 2, 2, 8'h00);
      checkOutput("t5_txn_after", {16'd0, txnA[0]}, 32'd1);

      // T2: zero wait, rq held high for 5 cycles yields a single ack
      sel = 1;
      applyStimulus(1, 1'b0, 4'd0, 8'h00, 0, 0, 8'h00);
      repeat (5) @(negedge clk);
      rqA[1] = 1'b0;
      @(negedge clk);
      doTxn(1, 1'b0, 4'd0, 8'h00, 0, 0, 8'h00);
      checkOutput("t2_txn", {16'd0, txnA[1]}, 32'd2);

      // T6: random waits, out-of-range writes ignored and read back as 0
      sel = 2;
      for (int i = 0; i < 32; i++) begin
         if (i < 12)
            doTxn(2, 1'b1, 4'(i), 8'(8'h40 + i), 0, 7, 8'h00);
         else if (i < 24)
            doTxn(2, 1'b0, 4'(i - 12), 8'h00, 0, 7, 8'(8'h40 + i - 12));
         else
            doTxn(2, 1'b1, 4'(12 + (i % 4)), 8'hFF, 0, 7, 8'h00);
      end
      doTxn(2, 1'b0, 4'd14, 8'h00, 0, 7, 8'h00);
      checkOutput("t6_txn", {16'd0, txnA[2]}, 32'd33);
      checkOutput("t6_err", {31'd0, errA[2]}, 32'd0);
      nDistinct = 0;
      for (int i = 0; i < 8; i++) if (latMask[i]) nDistinct++;
      checkOutput("t6_distinct_lat", {31'd0, (nDistinct >= 2)}, 32'd1);

      checkOutput("queue_empty", expQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
